// File: rtl/vy_hakem.sv
// Round-robin arbiter sharing the vy_denetleyici request/response channel between the L1 instruction and data caches.
// Latency: vy_istek_gecerli_o rises 1 cycle after requester gecerli; one outstanding transaction with a BOSTA bubble in between.
// Backpressure: istek/veri hazir pass straight through from the granted side; the losing port sees hazir=0 until granted.
module vy_hakem #(
    parameter int ADRES_BIT = 32,
    parameter int BLOK_BIT  = 128
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,

    input  logic [ADRES_BIT-1:0] l1b_istek_adres_i,
    input  logic                 l1b_istek_gecerli_i,
    input  logic                 l1b_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]  l1b_istek_veri_i,
    output logic                 l1b_istek_hazir_o,
    output logic [BLOK_BIT-1:0]  l1b_veri_o,
    output logic                 l1b_veri_gecerli_o,
    input  logic                 l1b_veri_hazir_i,

    input  logic [ADRES_BIT-1:0] l1v_istek_adres_i,
    input  logic                 l1v_istek_gecerli_i,
    input  logic                 l1v_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]  l1v_istek_veri_i,
    output logic                 l1v_istek_hazir_o,
    output logic [BLOK_BIT-1:0]  l1v_veri_o,
    output logic                 l1v_veri_gecerli_o,
    input  logic                 l1v_veri_hazir_i,

    output logic [ADRES_BIT-1:0] vy_istek_adres_o,
    output logic                 vy_istek_gecerli_o,
    output logic                 vy_istek_yaz_o,
    output logic [BLOK_BIT-1:0]  vy_istek_veri_o,
    input  logic                 vy_istek_hazir_i,
    input  logic [BLOK_BIT-1:0]  vy_veri_i,
    input  logic                 vy_veri_gecerli_i,
    output logic                 vy_veri_hazir_o,

    output logic [1:0]           aktif_port_o
);

    typedef enum logic [1:0] {
        BOSTA = 2'b00,
        ISTEK = 2'b01,
        YANIT = 2'b10
    } durum_t;

    localparam logic PORT_L1B = 1'b0;
    localparam logic PORT_L1V = 1'b1;

    durum_t durum_q, durum_d;
    logic   kazanan_q, kazanan_d;
    logic   son_izin_q, son_izin_d;

    // Live view of the granted requester; payload is held stable by the requester until its handshake.
    logic [ADRES_BIT-1:0] k_adres;
    logic                 k_gecerli;
    logic                 k_yaz;
    logic [BLOK_BIT-1:0]  k_veri;
    logic                 k_veri_hazir;

    always_comb begin
        if (kazanan_q == PORT_L1V) begin
            k_adres      = l1v_istek_adres_i;
            k_gecerli    = l1v_istek_gecerli_i;
            k_yaz        = l1v_istek_yaz_i;
            k_veri       = l1v_istek_veri_i;
            k_veri_hazir = l1v_veri_hazir_i;
        end else begin
            k_adres      = l1b_istek_adres_i;
            k_gecerli    = l1b_istek_gecerli_i;
            k_yaz        = l1b_istek_yaz_i;
            k_veri       = l1b_istek_veri_i;
            k_veri_hazir = l1b_veri_hazir_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum_q    <= BOSTA;
            kazanan_q  <= PORT_L1B;
            son_izin_q <= PORT_L1B;
        end else begin
            durum_q    <= durum_d;
            kazanan_q  <= kazanan_d;
            son_izin_q <= son_izin_d;
        end
    end

    always_comb begin
        durum_d            = durum_q;
        kazanan_d          = kazanan_q;
        son_izin_d         = son_izin_q;

        l1b_istek_hazir_o  = 1'b0;
        l1b_veri_o         = '0;
        l1b_veri_gecerli_o = 1'b0;
        l1v_istek_hazir_o  = 1'b0;
        l1v_veri_o         = '0;
        l1v_veri_gecerli_o = 1'b0;
        vy_istek_adres_o   = '0;
        vy_istek_gecerli_o = 1'b0;
        vy_istek_yaz_o     = 1'b0;
        vy_istek_veri_o    = '0;
        vy_veri_hazir_o    = 1'b0;
        aktif_port_o       = 2'b00;

        unique case (durum_q)
            BOSTA: begin
                if (l1b_istek_gecerli_i || l1v_istek_gecerli_i) begin
                    durum_d = ISTEK;
                    // On a tie the port that did not complete last wins.
                    if (l1b_istek_gecerli_i && l1v_istek_gecerli_i)
                        kazanan_d = ~son_izin_q;
                    else
                        kazanan_d = l1v_istek_gecerli_i ? PORT_L1V : PORT_L1B;
                end
            end

            ISTEK: begin
                aktif_port_o       = (kazanan_q == PORT_L1V) ? 2'b10 : 2'b01;
                vy_istek_adres_o   = k_adres;
                vy_istek_gecerli_o = k_gecerli;
                vy_istek_yaz_o     = k_yaz;
                vy_istek_veri_o    = k_veri;
                if (kazanan_q == PORT_L1V)
                    l1v_istek_hazir_o = vy_istek_hazir_i;
                else
                    l1b_istek_hazir_o = vy_istek_hazir_i;

                if (!k_gecerli) begin
                    // Requester withdrew before handshake: abandon without rotating priority.
                    durum_d = BOSTA;
                end else if (vy_istek_hazir_i) begin
                    if (k_yaz) begin
                        son_izin_d = kazanan_q;
                        durum_d    = BOSTA;
                    end else begin
                        durum_d    = YANIT;
                    end
                end
            end

            YANIT: begin
                aktif_port_o    = (kazanan_q == PORT_L1V) ? 2'b10 : 2'b01;
                vy_veri_hazir_o = k_veri_hazir;
                if (kazanan_q == PORT_L1V) begin
                    l1v_veri_o         = vy_veri_i;
                    l1v_veri_gecerli_o = vy_veri_gecerli_i;
                end else begin
                    l1b_veri_o         = vy_veri_i;
                    l1b_veri_gecerli_o = vy_veri_gecerli_i;
                end
                if (vy_veri_gecerli_i && k_veri_hazir) begin
                    son_izin_d = kazanan_q;
                    durum_d    = BOSTA;
                end
            end

            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

endmodule

// File: tb/tb_vy_hakem.sv
// Directed bench for vy_hakem: reset, single read, contention, write, backpressure, reset during response.
module tb_vy_hakem;

    localparam int AB = 32;
    localparam int BB = 128;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [AB-1:0] l1b_istek_adres_i, l1v_istek_adres_i;
    logic          l1b_istek_gecerli_i, l1v_istek_gecerli_i;
    logic          l1b_istek_yaz_i, l1v_istek_yaz_i;
    logic [BB-1:0] l1b_istek_veri_i, l1v_istek_veri_i;
    logic          l1b_istek_hazir_o, l1v_istek_hazir_o;
    logic [BB-1:0] l1b_veri_o, l1v_veri_o;
    logic          l1b_veri_gecerli_o, l1v_veri_gecerli_o;
    logic          l1b_veri_hazir_i, l1v_veri_hazir_i;
    logic [AB-1:0] vy_istek_adres_o;
    logic          vy_istek_gecerli_o, vy_istek_yaz_o;
    logic [BB-1:0] vy_istek_veri_o;
    logic          vy_istek_hazir_i;
    logic [BB-1:0] vy_veri_i;
    logic          vy_veri_gecerli_i;
    logic          vy_veri_hazir_o;
    logic [1:0]    aktif_port_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    vy_hakem #(.ADRES_BIT(AB), .BLOK_BIT(BB)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .l1b_istek_adres_i(l1b_istek_adres_i), .l1b_istek_gecerli_i(l1b_istek_gecerli_i),
        .l1b_istek_yaz_i(l1b_istek_yaz_i), .l1b_istek_veri_i(l1b_istek_veri_i),
        .l1b_istek_hazir_o(l1b_istek_hazir_o), .l1b_veri_o(l1b_veri_o),
        .l1b_veri_gecerli_o(l1b_veri_gecerli_o), .l1b_veri_hazir_i(l1b_veri_hazir_i),
        .l1v_istek_adres_i(l1v_istek_adres_i), .l1v_istek_gecerli_i(l1v_istek_gecerli_i),
        .l1v_istek_yaz_i(l1v_istek_yaz_i), .l1v_istek_veri_i(l1v_istek_veri_i),
        .l1v_istek_hazir_o(l1v_istek_hazir_o), .l1v_veri_o(l1v_veri_o),
        .l1v_veri_gecerli_o(l1v_veri_gecerli_o), .l1v_veri_hazir_i(l1v_veri_hazir_i),
        .vy_istek_adres_o(vy_istek_adres_o), .vy_istek_gecerli_o(vy_istek_gecerli_o),
        .vy_istek_yaz_o(vy_istek_yaz_o), .vy_istek_veri_o(vy_istek_veri_o),
        .vy_istek_hazir_i(vy_istek_hazir_i), .vy_veri_i(vy_veri_i),
        .vy_veri_gecerli_i(vy_veri_gecerli_i), .vy_veri_hazir_o(vy_veri_hazir_o),
        .aktif_port_o(aktif_port_o)
    );

    task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one posedge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, ".l1b_hazir"}, BB'(l1b_istek_hazir_o), '0);
        chk({tag, ".l1v_hazir"}, BB'(l1v_istek_hazir_o), '0);
        chk({tag, ".vy_gecerli"}, BB'(vy_istek_gecerli_o), '0);
        chk({tag, ".vy_veri_hazir"}, BB'(vy_veri_hazir_o), '0);
        chk({tag, ".l1b_vg"}, BB'(l1b_veri_gecerli_o), '0);
        chk({tag, ".l1v_vg"}, BB'(l1v_veri_gecerli_o), '0);
        chk({tag, ".aktif"}, BB'(aktif_port_o), BB'(2'b00));
    endtask

    logic [AB-1:0] mem_adres;
    logic [AB-1:0] exp_adres;
    logic [1:0]    exp_port;
    logic [AB-1:0] b_tag, v_tag;

    initial begin
        rstn_i = 1'b0;
        l1b_istek_adres_i = 32'h0000_1000; l1v_istek_adres_i = 32'h0000_2000;
        l1b_istek_gecerli_i = 1'b1; l1v_istek_gecerli_i = 1'b1;
        l1b_istek_yaz_i = 1'b0; l1v_istek_yaz_i = 1'b0;
        l1b_istek_veri_i = '0; l1v_istek_veri_i = '0;
        l1b_veri_hazir_i = 1'b0; l1v_veri_hazir_i = 1'b0;
        vy_istek_hazir_i = 1'b0; vy_veri_i = '0; vy_veri_gecerli_i = 1'b0;

        // Reset held 10 cycles with both requesters active.
        repeat (10) tick();
        idle_outs("reset");

        // First grant after release goes to l1v; then both withdraw.
        rstn_i = 1'b1;
        tick();
        chk("first_grant.aktif", BB'(aktif_port_o), BB'(2'b10));
        chk("first_grant.adres", BB'(vy_istek_adres_o), BB'(32'h0000_2000));
        chk("first_grant.l1b_hazir", BB'(l1b_istek_hazir_o), '0);
        l1b_istek_gecerli_i = 1'b0; l1v_istek_gecerli_i = 1'b0;
        tick();
        chk("withdraw.aktif", BB'(aktif_port_o), BB'(2'b00));

        // Single read from l1b.
        l1b_istek_adres_i = 32'h8000_0000; l1b_istek_gecerli_i = 1'b1;
        #1;
        chk("read.latency0", BB'(vy_istek_gecerli_o), '0);
        tick();
        chk("read.vy_gecerli", BB'(vy_istek_gecerli_o), BB'(1'b1));
        chk("read.adres", BB'(vy_istek_adres_o), BB'(32'h8000_0000));
        chk("read.yaz", BB'(vy_istek_yaz_o), '0);
        chk("read.aktif", BB'(aktif_port_o), BB'(2'b01));
        vy_istek_hazir_i = 1'b1;
        #1;
        chk("read.l1b_hazir", BB'(l1b_istek_hazir_o), BB'(1'b1));
        chk("read.l1v_hazir", BB'(l1v_istek_hazir_o), '0);
        tick();
        l1b_istek_gecerli_i = 1'b0; vy_istek_hazir_i = 1'b0;
        #1;
        chk("read.yanit_vy_gecerli", BB'(vy_istek_gecerli_o), '0);
        chk("read.yanit_aktif", BB'(aktif_port_o), BB'(2'b01));
        tick();
        vy_veri_i = {16{8'hA5}}; vy_veri_gecerli_i = 1'b1; l1b_veri_hazir_i = 1'b1;
        #1;
        chk("read.l1b_veri", l1b_veri_o, {16{8'hA5}});
        chk("read.l1b_vg", BB'(l1b_veri_gecerli_o), BB'(1'b1));
        chk("read.l1v_vg", BB'(l1v_veri_gecerli_o), '0);
        chk("read.l1v_veri", l1v_veri_o, '0);
        chk("read.vy_veri_hazir", BB'(vy_veri_hazir_o), BB'(1'b1));
        tick();
        vy_veri_gecerli_i = 1'b0; vy_veri_i = '0;
        #1;
        chk("read.done_aktif", BB'(aktif_port_o), BB'(2'b00));

        // Contention: l1b was last served, so grants go l1v, l1b, l1v, ...
        l1v_veri_hazir_i = 1'b1;
        b_tag = 32'h0000_0B00; v_tag = 32'h0000_0C00;
        l1b_istek_adres_i = b_tag; l1v_istek_adres_i = v_tag;
        l1b_istek_gecerli_i = 1'b1; l1v_istek_gecerli_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_port  = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_adres = (i % 2 == 0) ? v_tag : b_tag;
            tick();
            chk($sformatf("cont%0d.aktif", i), BB'(aktif_port_o), BB'(exp_port));
            chk($sformatf("cont%0d.adres", i), BB'(vy_istek_adres_o), BB'(exp_adres));
            vy_istek_hazir_i = 1'b1;
            #1;
            mem_adres = vy_istek_adres_o;
            tick();
            vy_istek_hazir_i = 1'b0;
            if (i % 2 == 0) begin
                v_tag = v_tag + 32'd1; l1v_istek_adres_i = v_tag;
            end else begin
                b_tag = b_tag + 32'd1; l1b_istek_adres_i = b_tag;
            end
            vy_veri_i = {4{mem_adres}}; vy_veri_gecerli_i = 1'b1;
            #1;
            if (i % 2 == 0) begin
                chk($sformatf("cont%0d.l1v_veri", i), l1v_veri_o, {4{exp_adres}});
                chk($sformatf("cont%0d.l1b_vg", i), BB'(l1b_veri_gecerli_o), '0);
            end else begin
                chk($sformatf("cont%0d.l1b_veri", i), l1b_veri_o, {4{exp_adres}});
                chk($sformatf("cont%0d.l1v_vg", i), BB'(l1v_veri_gecerli_o), '0);
            end
            tick();
            vy_veri_gecerli_i = 1'b0; vy_veri_i = '0;
            #1;
            chk($sformatf("cont%0d.bubble", i), BB'(aktif_port_o), BB'(2'b00));
        end
        l1b_istek_gecerli_i = 1'b0; l1v_istek_gecerli_i = 1'b0;
        l1b_veri_hazir_i = 1'b0; l1v_veri_hazir_i = 1'b0;
        tick();

        // Write from l1v with l1b queuing behind it.
        l1v_istek_adres_i = 32'h8000_0040; l1v_istek_yaz_i = 1'b1;
        l1v_istek_veri_i = {16{8'h11}}; l1v_istek_gecerli_i = 1'b1;
        vy_istek_hazir_i = 1'b1;
        tick();
        chk("write.aktif", BB'(aktif_port_o), BB'(2'b10));
        chk("write.yaz", BB'(vy_istek_yaz_o), BB'(1'b1));
        chk("write.veri", vy_istek_veri_o, {16{8'h11}});
        chk("write.adres", BB'(vy_istek_adres_o), BB'(32'h8000_0040));
        chk("write.l1v_hazir", BB'(l1v_istek_hazir_o), BB'(1'b1));
        chk("write.vy_veri_hazir", BB'(vy_veri_hazir_o), '0);
        l1b_istek_adres_i = 32'h8000_0080; l1b_istek_gecerli_i = 1'b1;
        tick();
        l1v_istek_gecerli_i = 1'b0; l1v_istek_yaz_i = 1'b0; vy_istek_hazir_i = 1'b0;
        #1;
        chk("write.bubble_aktif", BB'(aktif_port_o), BB'(2'b00));
        chk("write.bubble_vy_veri_hazir", BB'(vy_veri_hazir_o), '0);
        chk("write.bubble_vy_gecerli", BB'(vy_istek_gecerli_o), '0);
        tick();
        chk("after_write.aktif", BB'(aktif_port_o), BB'(2'b01));
        chk("after_write.adres", BB'(vy_istek_adres_o), BB'(32'h8000_0080));

        // Backpressure: request stalled 5 cycles, then response stalled 3 cycles.
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_req%0d.vy_gecerli", i), BB'(vy_istek_gecerli_o), BB'(1'b1));
            chk($sformatf("bp_req%0d.adres", i), BB'(vy_istek_adres_o), BB'(32'h8000_0080));
            chk($sformatf("bp_req%0d.l1b_hazir", i), BB'(l1b_istek_hazir_o), '0);
            tick();
        end
        chk("bp_req.still_istek", BB'(aktif_port_o), BB'(2'b01));
        vy_istek_hazir_i = 1'b1;
        #1;
        chk("bp_req.l1b_hazir", BB'(l1b_istek_hazir_o), BB'(1'b1));
        tick();
        l1b_istek_gecerli_i = 1'b0; vy_istek_hazir_i = 1'b0;
        vy_veri_i = {4{32'hDEAD_BEEF}}; vy_veri_gecerli_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_rsp%0d.l1b_veri", i), l1b_veri_o, {4{32'hDEAD_BEEF}});
            chk($sformatf("bp_rsp%0d.l1b_vg", i), BB'(l1b_veri_gecerli_o), BB'(1'b1));
            chk($sformatf("bp_rsp%0d.vy_veri_hazir", i), BB'(vy_veri_hazir_o), '0);
            tick();
        end
        chk("bp_rsp.still_yanit", BB'(aktif_port_o), BB'(2'b01));
        l1b_veri_hazir_i = 1'b1;
        #1;
        chk("bp_rsp.vy_veri_hazir", BB'(vy_veri_hazir_o), BB'(1'b1));
        tick();
        vy_veri_gecerli_i = 1'b0; vy_veri_i = '0; l1b_veri_hazir_i = 1'b0;
        #1;
        chk("bp_rsp.done_aktif", BB'(aktif_port_o), BB'(2'b00));

        // Reset while waiting for an l1v read response.
        l1v_istek_adres_i = 32'h0000_0300; l1v_istek_gecerli_i = 1'b1;
        vy_istek_hazir_i = 1'b1;
        tick();
        tick();
        l1v_istek_gecerli_i = 1'b0; vy_istek_hazir_i = 1'b0;
        #1;
        chk("rst_yanit.pre_aktif", BB'(aktif_port_o), BB'(2'b10));
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        vy_veri_i = {16{8'h5A}}; vy_veri_gecerli_i = 1'b1; l1v_veri_hazir_i = 1'b1;
        #1;
        idle_outs("rst_yanit");
        tick();
        vy_veri_gecerli_i = 1'b0; vy_veri_i = '0; l1v_veri_hazir_i = 1'b0;
        #1;
        chk("rst_yanit.after_aktif", BB'(aktif_port_o), BB'(2'b00));
        chk("rst_yanit.after_l1v_vg", BB'(l1v_veri_gecerli_o), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
